// File: rtl/dpr_fifo_ctrl_if.sv
// rtl/dpr_fifo_ctrl_if.sv - producer/consumer stream bundle for dpr_fifo_ctrl
interface dpr_fifo_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // master is the outside world (producer + consumer), slave is the controller
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dpr_fifo_ctrl.sv
// rtl/dpr_fifo_ctrl.sv - FIFO controller driving an external dual-port RAM with a show-ahead output register
module dpr_fifo_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    dpr_fifo_ctrl_if.slave       s,
    output logic                 ram_wen,
    output logic                 ram_pen0,
    output logic [AW-1:0]        ram_a0,
    output logic [DW-1:0]        ram_di,
    output logic                 ram_pen1,
    output logic [AW-1:0]        ram_a1,
    input  logic [DW-1:0]        ram_do1,
    output logic [AW:0]          level,
    output logic                 ovf_err
);

    generate
        if (DEPTH != (1 << AW)) begin : g_depth_check
            $fatal(1, "dpr_fifo_ctrl: DEPTH must equal 2**AW");
        end
    endgenerate

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          ovf_err_q, ovf_err_d;

    logic ram_full, ram_empty, push, pop, load, in_ready;

    always_comb begin
        ram_full  = (ram_cnt_q == DEPTH_C);
        ram_empty = (ram_cnt_q == '0);
        // ready depends only on registered count, never on same-cycle pop
        in_ready  = !ram_full && !RST;
        push      = s.in_valid && in_ready;
        pop       = out_valid_q && s.out_ready;
        // ram_empty excludes this cycle's push, so no read-during-write on one address
        load      = !ram_empty && (!out_valid_q || pop);

        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_data_d  = load ? ram_do1 : out_data_q;
        ovf_err_d   = ovf_err_q | (push && ram_full);

        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        ram_cnt_d = ram_cnt_q;
        if (push && !load) begin
            ram_cnt_d = ram_cnt_q + 1'b1;
        end else if (load && !push) begin
            ram_cnt_d = ram_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;

    assign ram_wen  = push;
    assign ram_pen0 = push;
    assign ram_a0   = wr_ptr_q;
    assign ram_di   = s.in_data;
    assign ram_pen1 = load;
    assign ram_a1   = rd_ptr_q;

    assign level   = ram_cnt_q + {{AW{1'b0}}, out_valid_q};
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
// tb/tb_dpr_fifo_ctrl.sv - directed self-checking bench for dpr_fifo_ctrl with a behavioural RAM
module tb_dpr_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ram_wen, ram_pen0, ram_pen1;
    logic [AW-1:0] ram_a0, ram_a1;
    logic [DW-1:0] ram_di, ram_do1;
    logic [AW:0]   level;
    logic          ovf_err;

    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    dpr_fifo_ctrl_if #(.DW(DW)) bus ();

    dpr_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .s        (bus),
        .ram_wen  (ram_wen),
        .ram_pen0 (ram_pen0),
        .ram_a0   (ram_a0),
        .ram_di   (ram_di),
        .ram_pen1 (ram_pen1),
        .ram_a1   (ram_a1),
        .ram_do1  (ram_do1),
        .level    (level),
        .ovf_err  (ovf_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ram_wen && ram_pen0) mem[ram_a0] <= ram_di;
    end
    assign ram_do1 = mem[ram_a1];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        RST = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;

        // reset and idle
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        #1;
        chk("rst_wen", 32'(ram_wen), 0);
        chk("rst_pen1", 32'(ram_pen1), 0);
        bus.in_valid = 1'b0;
        step();
        RST = 1'b0;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_level", 32'(level), 0);
        chk("idle_wen", 32'(ram_wen), 0);

        // single word
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        #1;
        chk("single_wen", 32'(ram_wen), 1);
        chk("single_pen0", 32'(ram_pen0), 1);
        chk("single_a0", 32'(ram_a0), 0);
        chk("single_di", 32'(ram_di), 32'hA5);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("single_n_out_valid", 32'(bus.out_valid), 0);
        chk("single_n_level", 32'(level), 1);
        chk("single_n_pen1", 32'(ram_pen1), 1);
        step();
        chk("single_out_valid", 32'(bus.out_valid), 1);
        chk("single_out_data", 32'(bus.out_data), 32'hA5);
        chk("single_level", 32'(level), 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        chk("single_pop_valid", 32'(bus.out_valid), 0);
        chk("single_pop_level", 32'(level), 0);

        // fill with 17 words; write pointer starts at 1 and wraps 15 -> 0
        for (int i = 0; i <= DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(i);
            #1;
            chk($sformatf("fill_ready_%0d", i), 32'(bus.in_ready), 1);
            chk($sformatf("fill_a0_%0d", i), 32'(ram_a0), 32'((i + 1) % DEPTH));
            step();
        end
        #1;
        chk("full_level", 32'(level), 17);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_wen", 32'(ram_wen), 0);
        chk("full_out_data", 32'(bus.out_data), 0);
        step();
        chk("full_hold_level", 32'(level), 17);
        bus.out_ready = 1'b1;
        #1;
        chk("full_no_ready_through", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b0;

        // drain
        for (int i = 0; i <= DEPTH; i++) begin
            #1;
            chk($sformatf("drain_valid_%0d", i), 32'(bus.out_valid), 1);
            chk($sformatf("drain_data_%0d", i), 32'(bus.out_data), 32'(i));
            chk($sformatf("drain_level_%0d", i), 32'(level), 32'(17 - i));
            step();
            if (i == 0) chk("drain_in_ready", 32'(bus.in_ready), 1);
        end
        bus.out_ready = 1'b0;
        #1;
        chk("drained_valid", 32'(bus.out_valid), 0);
        chk("drained_level", 32'(level), 0);

        // build level 5, then 40 cycles of simultaneous push/pop
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h50 + i);
            step();
        end
        chk("steady_start_level", 32'(level), 5);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_data = 8'(8'h60 + i);
            #1;
            chk($sformatf("steady_data_%0d", i), 32'(bus.out_data),
                (i < 5) ? 32'(8'h50 + i) : 32'(8'h60 + i - 5));
            chk($sformatf("steady_level_%0d", i), 32'(level), 5);
            step();
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("steady_ovf", 32'(ovf_err), 0);
        chk("steady_head", 32'(bus.out_data), 32'h60 + 35);

        // reset mid-stream
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h70 + i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_level", 32'(level), 9);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h3C;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_data", 32'(bus.out_data), 32'h3C);
        chk("post_rst_level", 32'(level), 1);
        chk("final_ovf", 32'(ovf_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
